wb_stage_hilo: RTL and testbench
================================

Name: wb_stage_hilo

Overview:
- Writeback-side consumer of the MEM/WB pipeline register outputs.
- Selects and gates the register-file write (memory data vs ALU result).
- Owns the architectural HI/LO registers, updated by mult/mthi/mtlo.
- Runs the arithmetic-overflow exception sequence: captures EPC, flushes the pipeline for a fixed number of cycles, then issues a one-cycle PC redirect to the handler.

Parameters:
- FLUSH_CYCLES, 3, number of cycles exc_flush is held high after an overflow is accepted (legal range 1..15).
- HANDLER_ADDR, 32'h0000_0180, PC value driven on exc_pc during redirect.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- MemtoReg  in  1  select Dout (1) or Result (0) as write data
- RegWr  in  1  instruction writes the register file
- Dout  in  32  load data from data memory
- Result  in  32  ALU result; also source operand for mthi/mtlo
- PC  in  32  PC of the instruction in writeback
- rw  in  5  destination register number
- Overflow  in  1  arithmetic overflow flagged for this instruction
- mtlo  in  1  write LO from Result
- mthi  in  1  write HI from Result
- mult  in  1  write {HI,LO} from mult_result
- mult_result  in  64  product, [63:32] to HI, [31:0] to LO
- wb_we  out  1  register-file write enable (combinational)
- wb_addr  out  5  register-file write address (= rw)
- wb_data  out  32  register-file write data (combinational)
- hi  out  32  HI register
- lo  out  32  LO register
- epc  out  32  PC of the last overflowing instruction
- exc_flush  out  1  squash IF..MEM stages
- exc_redirect  out  1  one-cycle PC load strobe
- exc_pc  out  32  redirect target
- perf_retired  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset, asynchronous and immediate:
  - hi=0, lo=0, epc=0, perf_retired=0
  - state=IDLE, exc_flush=0, exc_redirect=0, exc_pc=0
  - Reset asserted mid-FLUSH or mid-REDIRECT aborts the sequence at once.
- States: IDLE, FLUSH, REDIRECT. A 4-bit flush counter is internal.
- "accept" = state==IDLE && !Overflow.
- Register-file write, combinational, zero latency:
  - wb_data = MemtoReg ? Dout : Result
  - wb_addr = rw
  - wb_we = RegWr && accept && rw!=0
- HI/LO, registered on posedge clk, only when accept:
  - mult=1 -> hi<=mult_result[63:32], lo<=mult_result[31:0]; mthi/mtlo are ignored that cycle (mult has priority).
  - else mthi=1 -> hi<=Result; mtlo=1 -> lo<=Result. Both may fire in the same cycle.
  - When not accepted (overflow, or state!=IDLE), hi/lo hold.
- Exception entry:
  - In IDLE with Overflow=1 && RegWr=1: epc<=PC, state->FLUSH, counter<=FLUSH_CYCLES-1.
  - In IDLE with Overflow=1 && RegWr=0: the instruction is squashed but no exception is taken; state stays IDLE.
- FLUSH:
  - exc_flush=1 (registered, asserted the cycle after entry).
  - Counter decrements each cycle; at 0, state->REDIRECT.
  - All inputs are ignored, including new Overflow.
- REDIRECT:
  - Lasts exactly 1 cycle: exc_flush=0, exc_redirect=1, exc_pc=HANDLER_ADDR.
  - state->IDLE next cycle, where exc_redirect=0 and exc_pc holds its value.
- Overflow while not IDLE never re-enters and never overwrites epc.
- mult/mthi/mtlo with Overflow=1 are suppressed; no exception unless RegWr=1.

Optional Feature:
- Macro WB_PERF_COUNT_EN.
- Defined:
  - perf_retired increments by 1 on each posedge where accept && (RegWr || mult || mthi || mtlo).
  - Wraps from 32'hFFFF_FFFF to 0.
  - Cleared only by rst.
- Undefined: perf_retired is tied to 32'h0 and no counter logic exists.

Test Plan:
- Reset: rst=1 at arbitrary time with hi=5 -> hi, lo, epc, exc_flush, exc_redirect, and perf_retired read 0 immediately, before any clock edge.
- Load vs ALU write:
  - RegWr=1, MemtoReg=1, Dout=32'hDEAD_BEEF, Result=7, rw=8 -> wb_we=1, wb_addr=8, wb_data=32'hDEAD_BEEF.
  - Same with rw=0 -> wb_we=0.
- HI/LO:
  - mult=1, mult_result=64'h1234_5678_9ABC_DEF0 -> hi=32'h1234_5678, lo=32'h9ABC_DEF0 after the edge.
  - Next cycle mult=1, mthi=1, Result=1 -> hi=mult_result[63:32], not 1.
  - Then mthi=mtlo=1, Result=3 -> hi=lo=3.
- Overflow exception:
  - Overflow=1, RegWr=1, PC=32'h40 -> wb_we=0 that cycle; epc=32'h40.
  - exc_flush high for exactly 3 cycles, then exc_redirect high 1 cycle with exc_pc=32'h180, then IDLE.
- Overflow during FLUSH: second Overflow=1, RegWr=1, PC=32'h80 in the 2nd flush cycle -> epc stays 32'h40, redirect timing unchanged, hi/lo unchanged.
- WB_PERF_COUNT_EN defined:
  - 4 accepted RegWr cycles plus 1 overflowing cycle -> perf_retired=4.
  - Force count to 32'hFFFF_FFFF, retire 1 -> 0.

Source files
------------

// File: rtl/wb_stage_hilo.sv
// Writeback stage: register-file write gating, HI/LO registers and the overflow exception sequencer.
// Optional retired-instruction counter is built only when WB_PERF_COUNT_EN is defined.
module wb_stage_hilo #(
   parameter int unsigned FLUSH_CYCLES = 3,
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_0180
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemtoReg,
   input  logic        RegWr,
   input  logic [31:0] Dout,
   input  logic [31:0] Result,
   input  logic [31:0] PC,
   input  logic [4:0]  rw,
   input  logic        Overflow,
   input  logic        mtlo,
   input  logic        mthi,
   input  logic        mult,
   input  logic [63:0] mult_result,
   output logic        wb_we,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] epc,
   output logic        exc_flush,
   output logic        exc_redirect,
   output logic [31:0] exc_pc,
   output logic [31:0] perf_retired
);

   typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIRECT} state_t;

   localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] epc_q;
   logic        exc_flush_q;
   logic        exc_redirect_q;
   logic [31:0] exc_pc_q;
   logic        accept;

   // An overflowing instruction or any cycle of the exception sequence commits nothing.
   assign accept  = (state_q == S_IDLE) && !Overflow;

   assign wb_data = MemtoReg ? Dout : Result;
   assign wb_addr = rw;
   assign wb_we   = RegWr && accept && (rw != 5'd0);

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (accept) begin
         if (mult) begin
            hi_d = mult_result[63:32];
            lo_d = mult_result[31:0];
         end else begin
            if (mthi) hi_d = Result;
            if (mtlo) lo_d = Result;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q <= 32'h0;
         lo_q <= 32'h0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   // Exception sequencer: flush for FLUSH_CYCLES cycles, then a single redirect strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= 4'd0;
         epc_q          <= 32'h0;
         exc_flush_q    <= 1'b0;
         exc_redirect_q <= 1'b0;
         exc_pc_q       <= 32'h0;
      end else begin
         case (state_q)
            S_IDLE: begin
               exc_redirect_q <= 1'b0;
               if (Overflow && RegWr) begin
                  epc_q       <= PC;
                  cnt_q       <= CNT_INIT;
                  exc_flush_q <= 1'b1;
                  state_q     <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               if (cnt_q == 4'd0) begin
                  exc_flush_q    <= 1'b0;
                  exc_redirect_q <= 1'b1;
                  exc_pc_q       <= HANDLER_ADDR;
                  state_q        <= S_REDIRECT;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_REDIRECT: begin
               exc_redirect_q <= 1'b0;
               state_q        <= S_IDLE;
            end
            default: begin
               exc_flush_q    <= 1'b0;
               exc_redirect_q <= 1'b0;
               state_q        <= S_IDLE;
            end
         endcase
      end
   end

   assign hi           = hi_q;
   assign lo           = lo_q;
   assign epc          = epc_q;
   assign exc_flush    = exc_flush_q;
   assign exc_redirect = exc_redirect_q;
   assign exc_pc       = exc_pc_q;

`ifdef WB_PERF_COUNT_EN
   logic [31:0] perf_q;
   logic        retire;

   assign retire = accept && (RegWr || mult || mthi || mtlo);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_q <= 32'h0;
      end else if (retire) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign perf_retired = perf_q;
`else
   assign perf_retired = 32'h0;
`endif

endmodule

// File: tb/tb_wb_stage_hilo.sv
// Self-checking bench for wb_stage_hilo: directed vector table, exception/reset sequences, random run vs model.
module tb_wb_stage_hilo;

   localparam int unsigned FC      = 3;
   localparam logic [31:0] HANDLER = 32'h0000_0180;
`ifdef WB_PERF_COUNT_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        MemtoReg, RegWr, Overflow, mtlo, mthi, mult;
   logic [31:0] Dout, Result, PC;
   logic [4:0]  rw;
   logic [63:0] mult_result;
   logic        wb_we, exc_flush, exc_redirect;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data, hi, lo, epc, exc_pc, perf_retired;

   wb_stage_hilo #(.FLUSH_CYCLES(FC), .HANDLER_ADDR(HANDLER)) dut (
      .clk(clk), .rst(rst), .MemtoReg(MemtoReg), .RegWr(RegWr), .Dout(Dout),
      .Result(Result), .PC(PC), .rw(rw), .Overflow(Overflow), .mtlo(mtlo),
      .mthi(mthi), .mult(mult), .mult_result(mult_result), .wb_we(wb_we),
      .wb_addr(wb_addr), .wb_data(wb_data), .hi(hi), .lo(lo), .epc(epc),
      .exc_flush(exc_flush), .exc_redirect(exc_redirect), .exc_pc(exc_pc),
      .perf_retired(perf_retired)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: m_left counts cycles remaining in the exception sequence
   // (FC flush cycles followed by one redirect cycle); zero means idle.
   logic [31:0] m_hi, m_lo, m_epc, m_pc, m_perf;
   int          m_left;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_hi = 0; m_lo = 0; m_epc = 0; m_pc = 0; m_perf = 0; m_left = 0;
   endtask

   task automatic model_update();
      bit idle, acc;
      idle = (m_left == 0);
      acc  = idle && !Overflow;
      if (acc) begin
         if (mult) begin
            m_hi = mult_result[63:32];
            m_lo = mult_result[31:0];
         end else begin
            if (mthi) m_hi = Result;
            if (mtlo) m_lo = Result;
         end
         if (PERF_EN && (RegWr || mult || mthi || mtlo)) m_perf = m_perf + 32'd1;
      end
      if (!idle) begin
         m_left--;
         if (m_left == 1) m_pc = HANDLER;
      end else if (Overflow && RegWr) begin
         m_epc  = PC;
         m_left = FC + 1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst) model_update();
      #1;
   endtask

   task automatic clear_in();
      MemtoReg = 0; RegWr = 0; Overflow = 0; mtlo = 0; mthi = 0; mult = 0;
      Dout = 0; Result = 0; PC = 0; rw = 0; mult_result = 0;
   endtask

   task automatic check_all(input string tag);
      logic exp_we;
      exp_we = RegWr && (m_left == 0) && !Overflow && (rw != 0);
      chk({tag, ".wb_we"},   wb_we, exp_we);
      chk({tag, ".wb_addr"}, wb_addr, rw);
      chk({tag, ".wb_data"}, wb_data, MemtoReg ? Dout : Result);
      chk({tag, ".hi"},      hi, m_hi);
      chk({tag, ".lo"},      lo, m_lo);
      chk({tag, ".epc"},     epc, m_epc);
      chk({tag, ".flush"},   exc_flush, m_left > 1);
      chk({tag, ".redir"},   exc_redirect, m_left == 1);
      chk({tag, ".exc_pc"},  exc_pc, m_pc);
      chk({tag, ".perf"},    perf_retired, m_perf);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".hi"},     hi, 0);
      chk({tag, ".lo"},     lo, 0);
      chk({tag, ".epc"},    epc, 0);
      chk({tag, ".flush"},  exc_flush, 0);
      chk({tag, ".redir"},  exc_redirect, 0);
      chk({tag, ".exc_pc"}, exc_pc, 0);
      chk({tag, ".perf"},   perf_retired, 0);
   endtask

   // Asserts reset mid-cycle (away from any clock edge) and checks outputs clear immediately.
   task automatic apply_rst(input string tag);
      @(negedge clk);
      clear_in();
      #2 rst = 1;
      model_reset();
      #1 check_zero(tag);
      @(negedge clk);
      rst = 0;
   endtask

   typedef struct {
      logic        memtoreg, regwr;
      logic [31:0] dout, result;
      logic [4:0]  rw;
      logic        ovf, mthi, mtlo, mult;
      logic [63:0] mres;
      logic        exp_we;
      logic [31:0] exp_data, exp_hi, exp_lo;
   } vec_t;

   vec_t tbl[7];

   initial begin
      tbl[0] = '{1, 1, 32'hDEAD_BEEF, 32'd7, 5'd8, 0, 0, 0, 0, 64'h0, 1, 32'hDEAD_BEEF, 32'h0, 32'h0};
      tbl[1] = '{1, 1, 32'hDEAD_BEEF, 32'd7, 5'd0, 0, 0, 0, 0, 64'h0, 0, 32'hDEAD_BEEF, 32'h0, 32'h0};
      tbl[2] = '{0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1, 64'h1234_5678_9ABC_DEF0, 0, 32'h0, 32'h1234_5678, 32'h9ABC_DEF0};
      tbl[3] = '{0, 0, 32'h0, 32'd1, 5'd0, 0, 1, 0, 1, 64'h1234_5678_9ABC_DEF0, 0, 32'd1, 32'h1234_5678, 32'h9ABC_DEF0};
      tbl[4] = '{0, 0, 32'h0, 32'd3, 5'd0, 0, 1, 1, 0, 64'h0, 0, 32'd3, 32'd3, 32'd3};
      tbl[5] = '{0, 1, 32'hAAAA_5555, 32'd7, 5'd31, 0, 0, 0, 0, 64'h0, 1, 32'd7, 32'd3, 32'd3};
      tbl[6] = '{0, 0, 32'h0, 32'd9, 5'd4, 1, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 32'd9, 32'd3, 32'd3};

      clear_in();
      model_reset();
      #2 rst = 1;
      #1 check_zero("por");
      @(negedge clk);
      rst = 0;

      // Directed table: combinational write path, then HI/LO after the edge.
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         MemtoReg = tbl[i].memtoreg; RegWr = tbl[i].regwr; Dout = tbl[i].dout;
         Result = tbl[i].result; rw = tbl[i].rw; Overflow = tbl[i].ovf;
         mthi = tbl[i].mthi; mtlo = tbl[i].mtlo; mult = tbl[i].mult; mult_result = tbl[i].mres;
         #1;
         chk($sformatf("tbl%0d.we", i),   wb_we, tbl[i].exp_we);
         chk($sformatf("tbl%0d.addr", i), wb_addr, tbl[i].rw);
         chk($sformatf("tbl%0d.data", i), wb_data, tbl[i].exp_data);
         check_all($sformatf("tbl%0d", i));
         step();
         chk($sformatf("tbl%0d.hi", i),    hi, tbl[i].exp_hi);
         chk($sformatf("tbl%0d.lo", i),    lo, tbl[i].exp_lo);
         chk($sformatf("tbl%0d.flush", i), exc_flush, 0);
      end

      // Overflow exception, with a second overflow in the 2nd flush cycle.
      @(negedge clk);
      clear_in(); Overflow = 1; RegWr = 1; PC = 32'h40; rw = 5'd2; mthi = 1; Result = 32'd55;
      #1 chk("exc.entry_we", wb_we, 0);
      chk("exc.entry_flush", exc_flush, 0);
      step();
      @(negedge clk);
      clear_in();
      #1 chk("exc.f1", exc_flush, 1);
      chk("exc.epc", epc, 32'h40);
      check_all("exc.c1");
      step();
      @(negedge clk);
      clear_in(); Overflow = 1; RegWr = 1; PC = 32'h80; rw = 5'd3; mthi = 1; mult = 1; Result = 32'd99;
      mult_result = 64'h1111_2222_3333_4444;
      #1 chk("exc.f2", exc_flush, 1);
      chk("exc.f2_we", wb_we, 0);
      step();
      @(negedge clk);
      clear_in();
      #1 chk("exc.f3", exc_flush, 1);
      chk("exc.f3_redir", exc_redirect, 0);
      step();
      @(negedge clk);
      #1 chk("exc.r_flush", exc_flush, 0);
      chk("exc.r_redir", exc_redirect, 1);
      chk("exc.r_pc", exc_pc, 32'h180);
      chk("exc.r_epc", epc, 32'h40);
      check_all("exc.c4");
      step();
      @(negedge clk);
      #1 chk("exc.i_redir", exc_redirect, 0);
      chk("exc.i_pc", exc_pc, 32'h180);
      chk("exc.i_flush", exc_flush, 0);
      chk("exc.hi", hi, 32'd3);
      chk("exc.lo", lo, 32'd3);
      chk("exc.epc_kept", epc, 32'h40);

      // HI=5 then asynchronous reset between edges.
      @(negedge clk);
      clear_in(); mthi = 1; Result = 32'd5;
      step();
      chk("rst.hi5", hi, 32'd5);
      apply_rst("rst_async");

      // Retire count: 4 accepted writes then an overflowing one (which also starts a flush).
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         clear_in(); RegWr = 1; rw = 5'(i + 1); Result = 32'(i);
         step();
      end
      @(negedge clk);
      clear_in(); Overflow = 1; RegWr = 1; PC = 32'h100;
      step();
      @(negedge clk);
      clear_in();
      #1 chk("perf.four", perf_retired, PERF_EN ? 32'd4 : 32'd0);
      chk("perf.flush", exc_flush, 1);
      check_all("perf");
      apply_rst("rst_midflush");
      step();
      @(negedge clk);
      #1 chk("rst_midflush.redir", exc_redirect, 0);
      chk("rst_midflush.flush", exc_flush, 0);

`ifdef WB_PERF_COUNT_EN
      @(negedge clk);
      clear_in();
      force dut.perf_q = 32'hFFFF_FFFF;
      #1 release dut.perf_q;
      m_perf = 32'hFFFF_FFFF;
      RegWr = 1; rw = 5'd9;
      step();
      chk("perf.wrap", perf_retired, 32'h0);
`endif

      // Random run against the model.
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         MemtoReg    = 1'($urandom);
         RegWr       = 1'($urandom);
         Overflow    = ($urandom_range(0, 5) == 0);
         mthi        = ($urandom_range(0, 3) == 0);
         mtlo        = ($urandom_range(0, 3) == 0);
         mult        = ($urandom_range(0, 3) == 0);
         Dout        = $urandom;
         Result      = $urandom;
         PC          = {$urandom, 2'b00} >> 2 << 2;
         rw          = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
         mult_result = {$urandom, $urandom};
         #1 check_all($sformatf("rnd%0d", n));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
